// File: rtl/uart_tx_stream.sv
// uart_tx_stream: byte-stream 8N1 UART transmitter with request/advance source handshake
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1)
module uart_tx_stream #(
  parameter int CLKS_PER_BIT = 104,
  parameter int STOP_BITS    = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [7:0] i_data,
  input  logic       i_data_end,
  output logic       o_get_next,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP, DONE
  } state_t;
  state_t state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0] bits, bits_n;
  logic [7:0] shift, shift_n;
  logic last, last_n, tx_n, get_next_n, tick;
`ifdef UART_TX_PARITY_EN
  logic par, par_n;
`endif
  assign tick = baud == BW'(CLKS_PER_BIT - 1);
  assign o_busy = !(state == IDLE || state == DONE);
  assign o_done = state == DONE;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      baud       <= '0;
      bits       <= '0;
      shift      <= '0;
      last       <= 1'b0;
      o_tx       <= 1'b1;
      o_get_next <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      baud       <= baud_n;
      bits       <= bits_n;
      shift      <= shift_n;
      last       <= last_n;
      o_tx       <= tx_n;
      o_get_next <= get_next_n;
`ifdef UART_TX_PARITY_EN
      par        <= par_n;
`endif
    end
  end
  // Every transition happens on a tick, where baud wraps to 0, so each state starts at count 0
  always_comb begin
    state_n    = state;
    baud_n     = tick ? '0 : baud + 1'b1;
    bits_n     = bits;
    shift_n    = shift;
    last_n     = last;
    tx_n       = o_tx;
    get_next_n = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n      = par;
`endif
    case (state)
      IDLE: begin
        baud_n = '0;
        bits_n = '0;
        tx_n   = 1'b1;
        if (i_enable) begin
          state_n    = START;
          shift_n    = i_data;
          last_n     = i_data_end;
          get_next_n = !i_data_end;
          tx_n       = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_n      = ^i_data;
`endif
        end
      end
      START: if (tick) begin
        state_n = DATA;
        tx_n    = shift[0];
      end
      DATA: if (tick) begin
        if (bits == 3'd7) begin
          bits_n  = '0;
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
          tx_n    = par;
`else
          state_n = STOP;
          tx_n    = 1'b1;
`endif
        end else begin
          shift_n = shift >> 1;
          bits_n  = bits + 3'd1;
          tx_n    = shift[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) begin
        state_n = STOP;
        tx_n    = 1'b1;
      end
`endif
      STOP: if (tick) begin
        bits_n  = (bits == 3'(STOP_BITS - 1)) ? '0 : bits + 3'd1;
        state_n = (bits == 3'(STOP_BITS - 1)) ? (last ? DONE : IDLE) : STOP;
      end
      DONE: begin
        baud_n = '0;
        tx_n   = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: directed scoreboard bench decoding o_tx cycle by cycle
module tb_uart_tx_stream;
  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  logic clk = 0, rst = 1, en_a = 0, en_b = 0, src_mode = 0, end_r = 0, mon_b = 0;
  logic [7:0] data_r = 8'h00, data_a;
  logic [7:0] msg [3] = '{8'h48, 8'h69, 8'h21};
  logic end_a;
  logic [1:0] idx;
  logic gn_a, tx_a, busy_a, done_a, gn_b, tx_b, busy_b, done_b, mtx, mbusy;
  int gn_cnt, n_chk = 0, n_fail = 0, gap = 0, bad = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  // Registered byte source: advances one cycle after each get_next pulse
  always_ff @(posedge clk)
    if (rst) begin
      idx    <= '0;
      gn_cnt <= 0;
    end else begin
      idx    <= idx + {1'b0, gn_a};
      gn_cnt <= gn_cnt + int'(gn_a);
    end

  assign data_a = src_mode ? msg[idx] : data_r;
  assign end_a  = src_mode ? (idx == 2'd2) : end_r;
  assign mtx    = mon_b ? tx_b : tx_a;
  assign mbusy  = mon_b ? busy_b : busy_a;

  uart_tx_stream #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_enable(en_a), .i_data(data_a), .i_data_end(end_a),
    .o_get_next(gn_a), .o_tx(tx_a), .o_busy(busy_a), .o_done(done_a));

  uart_tx_stream #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_enable(en_b), .i_data(8'h00), .i_data_end(1'b1),
    .o_get_next(gn_b), .o_tx(tx_b), .o_busy(busy_b), .o_done(done_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for a start bit, then checks every cycle of the frame for the next queued byte
  task automatic check_frame(input string tag);
    logic [7:0] b;
    logic e;
    int nb;
    gap = 0;
    while (mtx !== 1'b0 && gap < 200) begin
      @(negedge clk);
      gap++;
    end
    chk({tag, " start_seen"}, gap < 200, 1);
    b  = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    nb = 9 + (mon_b ? 2 : 1) + PB;
    for (int k = 0; k < nb; k++) begin
      e = (k == 0) ? 1'b0 : (k <= 8) ? b[k-1] : (PB == 1 && k == 9) ? ^b : 1'b1;
      for (int c = 0; c < C; c++) begin
        chk($sformatf("%s bit%0d cyc%0d tx,busy", tag, k, c), {mtx, mbusy}, {e, 1'b1});
        @(negedge clk);
      end
    end
    chk({tag, " after_frame tx,busy"}, {mtx, mbusy}, 2'b10);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_gn", gn_a, 0);
    rst = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || gn_a !== 1'b0) bad++;
    end
    chk("enable_low_idle", bad, 0);
    data_r = 8'h48; en_a = 1; sb.push_back(8'h48);
    @(negedge clk);
    chk("x48_gn_pulse", gn_a, 1);
    chk("x48_start_next_edge", tx_a, 0);
    en_a = 0;
    check_frame("x48");
    chk("x48_gn_count", gn_cnt, 1);
    repeat (5) @(negedge clk);
    chk("idle_wait tx,busy", {tx_a, busy_a}, 2'b10);
    chk("idle_wait_gn_count", gn_cnt, 1);
    data_r = 8'hA5; en_a = 1;
    @(negedge clk);
    repeat (4 * C + 1) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("midrst_tx", tx_a, 1);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_done", done_a, 0);
    rst = 0; sb.delete(); sb.push_back(8'hA5);
    @(negedge clk);
    en_a = 0;
    chk("midrst_restart", tx_a, 0);
    check_frame("xA5_fresh");
    rst = 1;
    @(negedge clk);
    rst = 0; data_r = 8'h03; end_r = 0; en_a = 1;
    sb.push_back(8'h03); sb.push_back(8'h07);
    @(negedge clk);
    chk("x03_gn_pulse", gn_a, 1);
    data_r = 8'h07; end_r = 1;
    check_frame("x03");
    check_frame("x07");
    chk("x07_gap", gap, 1);
    chk("x07_done", done_a, 1);
    chk("x07_gn_count", gn_cnt, 1);
    rst = 1;
    @(negedge clk);
    rst = 0; src_mode = 1;
    sb.push_back(8'h48); sb.push_back(8'h69); sb.push_back(8'h21);
    check_frame("H");
    check_frame("i");
    chk("i_gap", gap, 1);
    check_frame("!");
    chk("bang_gap", gap, 1);
    chk("hi_done", done_a, 1);
    chk("hi_gn_count", gn_cnt, 2);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || done_a !== 1'b1 || gn_a !== 1'b0 || busy_a !== 1'b0) bad++;
    end
    chk("done_sticky", bad, 0);
    mon_b = 1; en_b = 1; sb.push_back(8'h00);
    @(negedge clk);
    en_b = 0;
    chk("two_stop_no_gn", gn_b, 0);
    check_frame("x00_two_stop");
    chk("two_stop_done", done_b, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
- Serial transmit stage that pulls bytes from an upstream byte source (message ROM / data generator) using a request/advance handshake.
- Emits 8N1 (optionally 8E1) UART frames on a single TX line, LSB first.
- Stops cleanly after the byte the source flags as last.
- Sits between the message source and the board TX pin.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per serial bit (12 MHz / 115200); legal range 4..65535.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  permission to start new frames; sampled only in IDLE.
- i_data  in  8  byte currently presented by the source.
- i_data_end  in  1  high when i_data is the final byte of the stream.
- o_get_next  out  1  one-cycle pulse: source must advance to the next byte.
- o_tx  out  1  serial line, idle high; driven from a flop.
- o_busy  out  1  high from START through the last stop bit.
- o_done  out  1  sticky; high once the final byte's stop bit has completed.

Behaviour:
- Reset values:
  - o_tx=1, o_get_next=0, o_busy=0, o_done=0.
  - State=IDLE; bit counter, baud counter and shift register cleared.
- Reset is synchronous and wins over all other events, including mid-frame. o_tx returns high on the reset edge, so a truncated frame is possible and accepted.
- States: IDLE, START, DATA, PARITY (feature only), STOP, DONE.
- IDLE:
  - If i_enable=1 and o_done=0 at an edge: latch i_data into the shift register and i_data_end into last_flag, then enter START.
  - On that same edge, o_get_next pulses high for exactly 1 cycle, unless i_data_end=1.
  - Otherwise remain in IDLE with o_tx=1.
- START: o_tx=0 for exactly CLKS_PER_BIT cycles.
- DATA:
  - 8 bits, LSB first; each bit held exactly CLKS_PER_BIT cycles.
  - Shift right on each bit boundary.
  - 3-bit counter; exit after bit 7.
- STOP:
  - o_tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - Then enter DONE if last_flag=1, else IDLE.
- DONE:
  - o_done=1, o_tx=1, o_busy=0.
  - No further o_get_next.
  - Exits only via i_reset.
- Baud counter:
  - Width is clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1; wraps to 0 at each bit boundary.
  - Reloaded to 0 on every state entry.
  - No drift across frames.
- o_tx timing:
  - The edge that leaves IDLE also drives o_tx=0 (registered).
  - Frame length exactly (10 + STOP_BITS - 1)*CLKS_PER_BIT cycles without parity.
- Back-to-back frames:
  - With i_enable held high, IDLE lasts exactly 1 cycle between frames. Line-idle gap = the STOP period plus 1 clock.
  - The source has at least CLKS_PER_BIT*10 cycles after o_get_next to settle the next byte. Registered sources with 2-cycle update latency are safe.
- i_enable low mid-frame: ignored; the current frame completes, then the block waits in IDLE.
- i_data / i_data_end changing mid-frame: ignored; only sampled on the IDLE exit edge.
- o_busy=1 exactly while state is START, DATA, PARITY or STOP.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - o_tx = XOR of the 8 latched data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame grows by one bit time.
- Undefined: no PARITY state, no parity logic; DATA goes directly to STOP.

Test Plan:
- CLKS_PER_BIT=4, i_enable=1, i_data=0x48, i_data_end=0 -> o_tx sequence per 4-cycle bit: 0,0,0,0,1,0,0,1,0,1; o_get_next single pulse on the IDLE-exit edge; o_busy high 40 cycles.
- Source stream "Hi!" with i_data_end asserted on '!' -> three frames separated by 1 idle cycle; exactly 2 o_get_next pulses; o_done rises after the 3rd stop bit; o_tx stays 1 afterwards.
- i_enable=0 for 50 cycles, then 1 -> o_tx stays 1 and no pulses until enable; the frame then starts on the next edge.
- Assert i_reset during DATA bit 3 -> next edge o_tx=1, o_busy=0, o_done=0; after release with i_enable=1, a full fresh frame is sent.
- STOP_BITS=2, CLKS_PER_BIT=4, 0x00 -> stop high for 8 cycles; total frame 44 cycles.
- UART_TX_PARITY_EN defined, bytes 0x03 and 0x07 -> parity bit 0 and 1 respectively; frame 44 cycles at CLKS_PER_BIT=4.
